enemy_pool: RTL and testbench

Parametrised successor to the single-walker enemy block: manages `N_SLOTS` independent walking enemies in one module.
- Per-slot features: spawn handshake, gravity and falling, ledge/pit death, a timed squish animation, Mario stomp and hurt detection, scroll shift, and a shared draw hit with slot index.
- Sits between the level/spawn controller, the tile collision poller, Mario's controller and the colour mapper.

---
 rtl/enemy_pool.sv | 276 +++++++++++++++++++++++++++
 tb/tb_enemy_pool.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_pool.sv
// Pool of N_SLOTS walking enemies: spawn handshake, gravity, despawn, squish, stomp/hurt
// detection, scroll shift and a shared pixel-hit lookup.
module enemy_pool #(
    parameter int unsigned N_SLOTS       = 4,
    parameter int unsigned X_SIZE        = 18,
    parameter int unsigned Y_SIZE        = 10,
    parameter int unsigned X_MIN         = 120,
    parameter int unsigned X_MAX         = 519,
    parameter int unsigned Y_MAX         = 439,
    parameter int unsigned X_STEP        = 1,
    parameter int unsigned GRAVITY       = 1,
    parameter int unsigned MAX_FALL      = 6,
    parameter int unsigned SHIFT_AMT     = 40,
    parameter int unsigned SQUISH_FRAMES = 30,
    parameter int unsigned MARIO_HH      = 20
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   frame_clk,
    input  logic                   spawn_valid,
    output logic                   spawn_ready,
    input  logic [9:0]             spawnX,
    input  logic [9:0]             spawnY,
    input  logic                   spawn_dir,
    input  logic                   kill_all,
    input  logic                   Shift,
    input  logic [9:0]             Mario_X_Pos,
    input  logic [9:0]             Mario_Y_Pos,
    input  logic                   Mario_falling,
    input  logic [N_SLOTS-1:0]     blocked_left,
    input  logic [N_SLOTS-1:0]     blocked_right,
    input  logic [N_SLOTS-1:0]     ground_below,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    output logic [N_SLOTS-1:0]     alive,
    output logic [10*N_SLOTS-1:0]  pos_x,
    output logic [10*N_SLOTS-1:0]  pos_y,
    output logic                   draw_is_enemy,
    output logic [2:0]             draw_slot,
    output logic                   draw_squished,
    output logic                   stomp_pulse,
    output logic [2:0]             stomp_slot,
    output logic                   hurt_mario
);

    localparam int unsigned CntW = (SQUISH_FRAMES < 2) ? 1 : $clog2(SQUISH_FRAMES + 1);

    localparam logic [10:0] XSize    = 11'(X_SIZE);
    localparam logic [10:0] YSizeL   = 11'(Y_SIZE);
    localparam logic [10:0] XMinL    = 11'(X_MIN);
    localparam logic [10:0] XMaxL    = 11'(X_MAX);
    localparam logic [10:0] YLimit   = 11'(Y_MAX + Y_SIZE);
    localparam logic [10:0] ShiftL   = 11'(SHIFT_AMT);
    localparam logic [10:0] MarioOfs = 11'(MARIO_HH + Y_SIZE);

    localparam logic [9:0] Step10  = 10'(X_STEP);
    localparam logic [9:0] Grav10  = 10'(GRAVITY);
    localparam logic [9:0] VMax10  = 10'(MAX_FALL);
    localparam logic [9:0] Shift10 = 10'(SHIFT_AMT);
    localparam logic [9:0] YSize10 = 10'(Y_SIZE);
    localparam logic [CntW-1:0] SquishLoad = CntW'(SQUISH_FRAMES);

    typedef enum logic [1:0] {StEmpty, StWalk, StFall, StSquish} slot_state_e;

    slot_state_e     state_q [N_SLOTS];
    slot_state_e     state_d [N_SLOTS];
    logic [9:0]      x_q     [N_SLOTS];
    logic [9:0]      x_d     [N_SLOTS];
    logic [9:0]      y_q     [N_SLOTS];
    logic [9:0]      y_d     [N_SLOTS];
    logic [9:0]      vel_q   [N_SLOTS];
    logic [9:0]      vel_d   [N_SLOTS];
    logic [CntW-1:0] cnt_q   [N_SLOTS];
    logic [CntW-1:0] cnt_d   [N_SLOTS];
    logic [N_SLOTS-1:0] dir_q, dir_d;

    logic frame_sync_q, frame_prev_q, frame_edge_q;
    logic stomp_pulse_q, hurt_q;
    logic [2:0] stomp_slot_q;

    logic [10:0] mario_x, mario_y;
    logic [N_SLOTS-1:0] walking, despawn, stomp_hit, hurt_hit;
    logic stomp_any, hurt_any, spawn_fire;
    logic [2:0] stomp_idx, spawn_idx;

    assign mario_x    = {1'b0, Mario_X_Pos};
    assign mario_y    = {1'b0, Mario_Y_Pos};
    assign spawn_fire = spawn_valid && spawn_ready;
    assign hurt_any   = |hurt_hit;

    // Per-slot classification against the pre-update state; all compares in 11 bits.
    always_comb begin
        logic [10:0] xw, yw;
        logic        in_x;
        xw        = '0;
        yw        = '0;
        in_x      = 1'b0;
        walking   = '0;
        despawn   = '0;
        stomp_hit = '0;
        hurt_hit  = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            xw   = {1'b0, x_q[i]};
            yw   = {1'b0, y_q[i]};
            in_x = (mario_x + XSize >= xw) && (mario_x < xw + XSize);
            walking[i] = (state_q[i] == StWalk) || (state_q[i] == StFall);
            despawn[i] = walking[i] && ((xw + XSize < XMinL) || (yw > YLimit) ||
                                        (Shift && (xw < ShiftL)));
            stomp_hit[i] = walking[i] && !despawn[i] && in_x && Mario_falling &&
                           (mario_y + MarioOfs == yw);
            hurt_hit[i]  = walking[i] && !despawn[i] && in_x &&
                           (mario_y < yw + MarioOfs) && (mario_y + MarioOfs > yw);
        end
    end

    always_comb begin
        stomp_any   = 1'b0;
        stomp_idx   = '0;
        spawn_ready = 1'b0;
        spawn_idx   = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (stomp_hit[i] && !stomp_any) begin
                stomp_any = 1'b1;
                stomp_idx = 3'(i);
            end
            if (state_q[i] == StEmpty && !spawn_ready) begin
                spawn_ready = 1'b1;
                spawn_idx   = 3'(i);
            end
        end
    end

    // Slot next state: kill_all beats spawn, spawn beats the frame update.
    always_comb begin
        logic       nd;
        logic [9:0] nv;
        nd = 1'b0;
        nv = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            vel_d[i]   = vel_q[i];
            cnt_d[i]   = cnt_q[i];
            dir_d[i]   = dir_q[i];
            if (kill_all) begin
                state_d[i] = StEmpty;
            end else if (spawn_fire && spawn_idx == 3'(i)) begin
                state_d[i] = StWalk;
                x_d[i]     = spawnX;
                y_d[i]     = spawnY - YSize10;
                vel_d[i]   = '0;
                cnt_d[i]   = '0;
                dir_d[i]   = spawn_dir;
            end else if (frame_edge_q) begin
                case (state_q[i])
                    StWalk, StFall: begin
                        if (despawn[i]) begin
                            state_d[i] = StEmpty;
                        end else if (stomp_any && stomp_idx == 3'(i)) begin
                            state_d[i] = StSquish;
                            cnt_d[i]   = SquishLoad;
                            vel_d[i]   = '0;
                        end else begin
                            nd = dir_q[i];
                            if (blocked_left[i]) begin
                                nd = 1'b1;
                            end else if (blocked_right[i] || ({1'b0, x_q[i]} + XSize >= XMaxL)) begin
                                nd = 1'b0;
                            end
                            dir_d[i] = nd;
                            if (Shift)   x_d[i] = x_q[i] - Shift10;
                            else if (nd) x_d[i] = x_q[i] + Step10;
                            else         x_d[i] = x_q[i] - Step10;
                            if (ground_below[i]) begin
                                state_d[i] = StWalk;
                                vel_d[i]   = '0;
                            end else begin
                                nv = vel_q[i] + Grav10;
                                if (nv > VMax10) nv = VMax10;
                                vel_d[i]   = nv;
                                y_d[i]     = y_q[i] + nv;
                                state_d[i] = StFall;
                            end
                        end
                    end
                    StSquish: begin
                        if (Shift) x_d[i] = x_q[i] - Shift10;
                        if (cnt_q[i] <= CntW'(1)) state_d[i] = StEmpty;
                        else                      cnt_d[i]   = cnt_q[i] - CntW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_sync_q  <= 1'b0;
            frame_prev_q  <= 1'b0;
            frame_edge_q  <= 1'b0;
            stomp_pulse_q <= 1'b0;
            stomp_slot_q  <= '0;
            hurt_q        <= 1'b0;
            dir_q         <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                state_q[i] <= StEmpty;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                vel_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            frame_sync_q  <= frame_clk;
            frame_prev_q  <= frame_sync_q;
            frame_edge_q  <= frame_sync_q & ~frame_prev_q;
            stomp_pulse_q <= frame_edge_q && stomp_any && !kill_all;
            stomp_slot_q  <= (frame_edge_q && stomp_any && !kill_all) ? stomp_idx : 3'd0;
            hurt_q        <= frame_edge_q && hurt_any && !stomp_any && !kill_all;
            dir_q         <= dir_d;
            for (int i = 0; i < N_SLOTS; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                vel_q[i]   <= vel_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign stomp_pulse = stomp_pulse_q;
    assign stomp_slot  = stomp_slot_q;
    assign hurt_mario  = hurt_q;

    always_comb begin
        alive = '0;
        pos_x = '0;
        pos_y = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            alive[i]          = state_q[i] != StEmpty;
            pos_x[10*i +: 10] = x_q[i];
            pos_y[10*i +: 10] = y_q[i];
        end
    end

    // Squished enemies only occupy the lower half of their box.
    always_comb begin
        logic [10:0] dx, dy, xw, yw;
        logic        in_x;
        dx            = {1'b0, DrawX};
        dy            = {1'b0, DrawY};
        xw            = '0;
        yw            = '0;
        in_x          = 1'b0;
        draw_is_enemy = 1'b0;
        draw_slot     = '0;
        draw_squished = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            xw   = {1'b0, x_q[i]};
            yw   = {1'b0, y_q[i]};
            in_x = (dx + XSize >= xw) && (dx < xw + XSize);
            if (!draw_is_enemy && in_x) begin
                if (walking[i] && (dy + YSizeL >= yw) && (dy < yw + YSizeL)) begin
                    draw_is_enemy = 1'b1;
                    draw_slot     = 3'(i);
                end else if (state_q[i] == StSquish && (dy >= yw) && (dy < yw + YSizeL)) begin
                    draw_is_enemy = 1'b1;
                    draw_slot     = 3'(i);
                    draw_squished = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_enemy_pool.sv
// Bench for enemy_pool: directed scenarios then randomized frames, checked against a
// slot-level behavioural model.
module tb_enemy_pool;
    localparam int N = 4;

    logic Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
    logic spawn_valid = 1'b0, spawn_dir = 1'b0, kill_all = 1'b0, Shift = 1'b0;
    logic Mario_falling = 1'b0;
    logic [9:0] spawnX = '0, spawnY = '0, Mario_X_Pos = '0, Mario_Y_Pos = '0;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic [N-1:0] blocked_left = '0, blocked_right = '0, ground_below = '1;
    logic spawn_ready, draw_is_enemy, draw_squished, stomp_pulse, hurt_mario;
    logic [2:0] draw_slot, stomp_slot;
    logic [N-1:0] alive;
    logic [10*N-1:0] pos_x, pos_y;

    enemy_pool dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
        .spawnX(spawnX), .spawnY(spawnY), .spawn_dir(spawn_dir),
        .kill_all(kill_all), .Shift(Shift),
        .Mario_X_Pos(Mario_X_Pos), .Mario_Y_Pos(Mario_Y_Pos), .Mario_falling(Mario_falling),
        .blocked_left(blocked_left), .blocked_right(blocked_right), .ground_below(ground_below),
        .DrawX(DrawX), .DrawY(DrawY),
        .alive(alive), .pos_x(pos_x), .pos_y(pos_y),
        .draw_is_enemy(draw_is_enemy), .draw_slot(draw_slot), .draw_squished(draw_squished),
        .stomp_pulse(stomp_pulse), .stomp_slot(stomp_slot), .hurt_mario(hurt_mario)
    );

    always #5 Clk = ~Clk;

    int checks = 0, errors = 0;

    // Model: kind 0 = gone, 1 = walker (walking or falling), 2 = squished
    int m_kind[N], m_x[N], m_y[N], m_v[N], m_dir[N], m_cnt[N];

    function automatic int wrap(input int v);
        return ((v % 1024) + 1024) % 1024;
    endfunction

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_state(input string tag);
        logic [N-1:0] ea;
        logic [10*N-1:0] ex, ey, mask;
        ea = '0; ex = '0; ey = '0; mask = '0;
        for (int i = 0; i < N; i++) begin
            if (m_kind[i] != 0) begin
                ea[i] = 1'b1;
                ex[10*i +: 10] = 10'(m_x[i]);
                ey[10*i +: 10] = 10'(m_y[i]);
                mask[10*i +: 10] = '1;
            end
        end
        check({tag, ".alive"}, alive, ea);
        check({tag, ".ready"}, spawn_ready, ea != '1);
        check({tag, ".pos_x"}, pos_x & mask, ex);
        check({tag, ".pos_y"}, pos_y & mask, ey);
    endtask

    task automatic spawn(input int sx, input int sy, input bit d, input bit chk);
        bit done;
        @(negedge Clk);
        spawnX = 10'(sx); spawnY = 10'(sy); spawn_dir = d; spawn_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!done && m_kind[i] == 0) begin
                done = 1'b1;
                m_kind[i] = 1; m_x[i] = sx; m_y[i] = sy - 10; m_v[i] = 0; m_dir[i] = d;
            end
        end
        @(posedge Clk);
        #1 spawn_valid = 1'b0;
        if (chk) begin
            @(negedge Clk);
            compare_state("spawn");
        end
    endtask

    task automatic kill();
        @(negedge Clk);
        kill_all = 1'b1;
        for (int i = 0; i < N; i++) m_kind[i] = 0;
        @(negedge Clk);
        kill_all = 1'b0;
        compare_state("kill");
    endtask

    task automatic model_frame(input bit sh, input logic [N-1:0] gb, bl, br,
                               input int mx, input int my, input bit mf,
                               output bit st, output int ss, output bit hu);
        bit gone[N], sq[N], hq[N], inx;
        st = 0; ss = 0; hu = 0;
        for (int i = 0; i < N; i++) begin
            gone[i] = 0; sq[i] = 0; hq[i] = 0;
            if (m_kind[i] == 1) begin
                gone[i] = (m_x[i] + 18 < 120) || (m_y[i] - 10 > 439) || (sh && m_x[i] < 40);
                inx = (m_x[i] - 18 <= mx) && (mx < m_x[i] + 18);
                sq[i] = !gone[i] && inx && mf && (my + 20 == m_y[i] - 10);
                hq[i] = !gone[i] && inx && (my - 20 < m_y[i] + 10) && (my + 20 > m_y[i] - 10);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (sq[i] && !st) begin st = 1; ss = i; end
            if (hq[i]) hu = 1;
        end
        if (st) hu = 0;
        for (int i = 0; i < N; i++) begin
            if (m_kind[i] == 1) begin
                if (gone[i]) m_kind[i] = 0;
                else if (st && ss == i) begin m_kind[i] = 2; m_cnt[i] = 30; end
                else begin
                    if (bl[i]) m_dir[i] = 1;
                    else if (br[i] || m_x[i] + 18 >= 519) m_dir[i] = 0;
                    m_x[i] = wrap(m_x[i] + (sh ? -40 : (m_dir[i] != 0 ? 1 : -1)));
                    if (gb[i]) m_v[i] = 0;
                    else begin
                        m_v[i] = (m_v[i] + 1 > 6) ? 6 : m_v[i] + 1;
                        m_y[i] = wrap(m_y[i] + m_v[i]);
                    end
                end
            end else if (m_kind[i] == 2) begin
                if (sh) m_x[i] = wrap(m_x[i] - 40);
                if (m_cnt[i] <= 1) m_kind[i] = 0;
                else m_cnt[i]--;
            end
        end
    endtask

    task automatic frame(input bit sh, input logic [N-1:0] gb, bl, br,
                         input int mx, input int my, input bit mf, input string tag);
        bit est, ehu;
        int ess, sp_cnt, hu_cnt, sp_slot;
        @(negedge Clk);
        Shift = sh; ground_below = gb; blocked_left = bl; blocked_right = br;
        Mario_X_Pos = 10'(mx); Mario_Y_Pos = 10'(my); Mario_falling = mf;
        frame_clk = 1'b1;
        model_frame(sh, gb, bl, br, mx, my, mf, est, ess, ehu);
        sp_cnt = 0; hu_cnt = 0; sp_slot = 0;
        repeat (6) @(negedge Clk) begin
            if (stomp_pulse) begin sp_cnt++; sp_slot = int'(stomp_slot); end
            if (hurt_mario) hu_cnt++;
        end
        frame_clk = 1'b0; Shift = 1'b0;
        repeat (2) @(negedge Clk);
        check({tag, ".stomp_cycles"}, sp_cnt, est ? 1 : 0);
        if (est) check({tag, ".stomp_slot"}, sp_slot, ess);
        check({tag, ".hurt_cycles"}, hu_cnt, ehu ? 1 : 0);
        compare_state(tag);
    endtask

    task automatic idle_frame(input bit sh, input string tag);
        frame(sh, '1, '0, '0, 0, 0, 1'b0, tag);
    endtask

    task automatic draw_check(input int dx, input int dy, input string tag);
        int hit;
        bit sq;
        logic [4:0] exp;
        @(negedge Clk);
        DrawX = 10'(dx); DrawY = 10'(dy);
        #1;
        hit = -1; sq = 0;
        for (int i = 0; i < N; i++) begin
            if (hit < 0 && m_kind[i] != 0 && m_x[i] - 18 <= dx && dx < m_x[i] + 18) begin
                if (m_kind[i] == 1 && m_y[i] - 10 <= dy && dy < m_y[i] + 10) hit = i;
                else if (m_kind[i] == 2 && m_y[i] <= dy && dy < m_y[i] + 10) begin
                    hit = i; sq = 1;
                end
            end
        end
        exp = (hit < 0) ? 5'd0 : {1'b1, 3'(hit), sq};
        check(tag, {draw_is_enemy, draw_slot, draw_squished}, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int r, t, mode, mx, my;
        bit mf, sh;
        logic [N-1:0] gb, bl, br;
        for (int i = 0; i < N; i++) begin
            m_kind[i] = 0; m_x[i] = 0; m_y[i] = 0; m_v[i] = 0; m_dir[i] = 0; m_cnt[i] = 0;
        end

        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("reset.alive", alive, 0);
        check("reset.pos_x", pos_x, 0);
        check("reset.ready", spawn_ready, 1);
        check("reset.stomp", {stomp_pulse, stomp_slot, hurt_mario}, 0);
        check("reset.draw", draw_is_enemy, 0);

        // Spawn and walk
        spawn(200, 300, 1'b0, 1'b1);
        check("walk.y", pos_y[9:0], 290);
        for (int k = 0; k < 5; k++) idle_frame(1'b0, "walk");
        check("walk.x", pos_x[9:0], 195);

        // Pool full, then refill a despawned slot
        kill();
        spawn(200, 300, 1'b0, 1'b0);
        spawn(250, 200, 1'b1, 1'b0);
        spawn(50, 300, 1'b0, 1'b0);
        spawn(400, 300, 1'b0, 1'b1);
        check("full.alive", alive, 4'hF);
        check("full.ready", spawn_ready, 0);
        spawn(333, 333, 1'b0, 1'b1);
        idle_frame(1'b0, "full.despawn");
        check("full.slot2_gone", alive, 4'b1011);
        spawn(320, 260, 1'b1, 1'b1);
        check("full.slot2_x", pos_x[29:20], 320);

        // Gravity
        kill();
        spawn(300, 210, 1'b0, 1'b1);
        frame(1'b0, '0, '0, '0, 0, 0, 1'b0, "fall1");
        check("fall1.y", pos_y[9:0], 201);
        frame(1'b0, '0, '0, '0, 0, 0, 1'b0, "fall2");
        check("fall2.y", pos_y[9:0], 203);
        frame(1'b0, '0, '0, '0, 0, 0, 1'b0, "fall3");
        check("fall3.y", pos_y[9:0], 206);
        idle_frame(1'b0, "land");
        check("land.y", pos_y[9:0], 206);

        // Stomp and squish lifetime
        kill();
        spawn(300, 300, 1'b0, 1'b1);
        frame(1'b0, '1, '0, '0, 305, 260, 1'b1, "stomp");
        check("stomp.x_frozen", pos_x[9:0], 300);
        draw_check(300, 289, "sq.above");
        draw_check(300, 290, "sq.top");
        draw_check(300, 299, "sq.bottom");
        draw_check(300, 300, "sq.below");
        draw_check(282, 295, "sq.left");
        draw_check(318, 295, "sq.right");
        for (int k = 0; k < 29; k++) idle_frame(1'b0, "squish");
        check("squish.alive29", alive[0], 1);
        idle_frame(1'b0, "squish.end");
        check("squish.gone30", alive[0], 0);

        // Hurt
        kill();
        spawn(300, 300, 1'b0, 1'b1);
        frame(1'b0, '1, '0, '0, 300, 290, 1'b0, "hurt1");
        frame(1'b0, '1, '0, '0, 300, 290, 1'b0, "hurt2");
        check("hurt.alive", alive[0], 1);
        draw_check(300, 285, "hurt.draw");

        // Scroll and edge despawn
        kill();
        spawn(150, 300, 1'b0, 1'b1);
        idle_frame(1'b1, "scroll1");
        check("scroll1.x", pos_x[9:0], 110);
        idle_frame(1'b0, "scroll2");
        check("scroll2.alive", alive[0], 1);
        idle_frame(1'b1, "scroll3");
        idle_frame(1'b0, "scroll4");
        check("scroll4.gone", alive[0], 0);
        spawn(30, 300, 1'b0, 1'b1);
        idle_frame(1'b1, "scroll5");
        check("scroll5.gone", alive[0], 0);

        // Randomized frames, spawns and kills
        kill();
        for (int it = 0; it < 150; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3) begin
                spawn(int'($urandom_range(100, 540)), int'($urandom_range(60, 440)),
                      1'($urandom), 1'b1);
            end else if (r == 3 && $urandom_range(0, 3) == 0) begin
                kill();
            end else begin
                t    = int'($urandom_range(0, N - 1));
                mode = int'($urandom_range(0, 2));
                mx   = m_x[t] + int'($urandom_range(0, 40)) - 20;
                if (mode == 0) begin
                    my = m_y[t] - 30; mf = 1'b1;
                end else if (mode == 1) begin
                    my = m_y[t] + int'($urandom_range(0, 60)) - 30; mf = 1'($urandom);
                end else begin
                    mx = int'($urandom_range(0, 1023)); my = int'($urandom_range(0, 1023));
                    mf = 1'($urandom);
                end
                sh = ($urandom_range(0, 7) == 0);
                gb = N'($urandom) | N'($urandom);
                bl = N'($urandom) & N'($urandom) & N'($urandom);
                br = N'($urandom) & N'($urandom) & N'($urandom);
                frame(sh, gb, bl, br, clamp(mx), clamp(my), mf, "rand");
                for (int k = 0; k < 2; k++)
                    draw_check(clamp(m_x[t] + int'($urandom_range(0, 44)) - 22),
                               clamp(m_y[t] + int'($urandom_range(0, 26)) - 13), "rand.draw");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
